// File: rtl/noc_vc_alloc_demux_if.sv
// ---------------------------------------------------------------------------
// noc_vc_alloc_demux_if
// Signal bundle between a NoC link receiver, the VC allocator/demultiplexer
// and the per-VC input buffers of a router port.
//   receive side : Noc_receive_valid/ready/flit/is_header/is_tail (one link)
//   sender side  : Noc_sender_valid/ready/flit/VCready/is_header/is_tail
//                  (VC_NUM lanes, VC i flit at [i*DATA_WIDTH +: DATA_WIDTH])
//   status       : Noc_vc_grant (one-hot bound VC), Noc_vc_busy, Noc_drop_err
// Modports:
//   slave  - the allocator/demultiplexer itself
//   master - the surrounding environment (link receiver + VC buffers)
// ---------------------------------------------------------------------------
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_vc_alloc_demux_if #(
    parameter int DATA_WIDTH = `Noc_Data_Width,
    parameter int VC_NUM     = 2
);
    logic                         Noc_receive_valid;
    logic                         Noc_receive_ready;
    logic [DATA_WIDTH-1:0]        Noc_receive_flit;
    logic                         Noc_receive_is_header;
    logic                         Noc_receive_is_tail;
    logic [VC_NUM-1:0]            Noc_sender_valid;
    logic [VC_NUM-1:0]            Noc_sender_ready;
    logic [VC_NUM*DATA_WIDTH-1:0] Noc_sender_flit;
    logic [VC_NUM-1:0]            Noc_sender_VCready;
    logic [VC_NUM-1:0]            Noc_sender_is_header;
    logic [VC_NUM-1:0]            Noc_sender_is_tail;
    logic [VC_NUM-1:0]            Noc_vc_grant;
    logic                         Noc_vc_busy;
    logic                         Noc_drop_err;

    modport slave (
        input  Noc_receive_valid, Noc_receive_flit, Noc_receive_is_header,
               Noc_receive_is_tail, Noc_sender_ready, Noc_sender_VCready,
        output Noc_receive_ready, Noc_sender_valid, Noc_sender_flit,
               Noc_sender_is_header, Noc_sender_is_tail, Noc_vc_grant,
               Noc_vc_busy, Noc_drop_err
    );

    modport master (
        output Noc_receive_valid, Noc_receive_flit, Noc_receive_is_header,
               Noc_receive_is_tail, Noc_sender_ready, Noc_sender_VCready,
        input  Noc_receive_ready, Noc_sender_valid, Noc_sender_flit,
               Noc_sender_is_header, Noc_sender_is_tail, Noc_vc_grant,
               Noc_vc_busy, Noc_drop_err
    );
endinterface

// File: rtl/noc_vc_alloc_demux.sv
// ---------------------------------------------------------------------------
// noc_vc_alloc_demux
// Packet-level virtual-channel allocator and demultiplexer for one NoC input
// link. A header waits in ALLOC until a VC reports VCready; the winner is
// chosen round-robin starting at rr_ptr and stays bound until the tail flit
// transfers. While bound, flits and backpressure are steered combinationally
// to/from that VC only. Non-header flits seen while idle are consumed and
// flagged on the sticky Noc_drop_err.
// Ports:
//   noc_clk, noc_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : receive link, per-VC sender lanes and status
//   Noc_timeout        : 1-cycle stall-watchdog pulse (optional build only)
// Optional feature macro: NOC_VC_STALL_TIMEOUT_EN
//   adds a BUSY stall counter and the Noc_timeout output; TIMEOUT_CYCLES is
//   the watchdog limit.
// ---------------------------------------------------------------------------
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_vc_alloc_demux #(
    parameter int DATA_WIDTH     = `Noc_Data_Width,
    parameter int VC_NUM         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                noc_clk,
    input  logic                noc_rst_n,
    noc_vc_alloc_demux_if.slave bus
`ifdef NOC_VC_STALL_TIMEOUT_EN
    ,
    output logic                Noc_timeout
`endif
);

    localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(VC_NUM - 1);
    localparam logic [PTR_W:0]   VC_NUM_W  = (PTR_W + 1)'(VC_NUM);

    // Elaboration-time guard on the supported configuration range
    if ((VC_NUM < 2) || (VC_NUM > 8) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_invalid
        $error("noc_vc_alloc_demux: VC_NUM must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [VC_NUM-1:0] grant_r, grant_nxt_s;
    logic [PTR_W-1:0]  vc_idx_r, vc_idx_nxt_s;
    logic [PTR_W-1:0]  rr_ptr_r, rr_ptr_nxt_s;
    logic              drop_err_r, drop_err_nxt_s;
    logic              found_s;
    logic [PTR_W-1:0]  win_s;
    logic [PTR_W:0]    idx_s;
    logic              xfer_s;

    // Round-robin successor of a VC index, wrapping at VC_NUM-1
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_IDX) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Round-robin search of VCready starting at rr_ptr; first ready VC wins
    always_comb begin
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        idx_s   = {(PTR_W+1){1'b0}};
        for (int i = 0; i < VC_NUM; i++) begin
            idx_s = {1'b0, rr_ptr_r} + (PTR_W + 1)'(i);
            if (idx_s >= VC_NUM_W) begin
                idx_s = idx_s - VC_NUM_W;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && bus.Noc_sender_VCready[idx_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Link-side ready and combinational steering of flits to the bound VC
    always_comb begin
        bus.Noc_receive_ready    = 1'b0;
        bus.Noc_sender_valid     = {VC_NUM{1'b0}};
        bus.Noc_sender_flit      = {(VC_NUM*DATA_WIDTH){1'b0}};
        bus.Noc_sender_is_header = {VC_NUM{1'b0}};
        bus.Noc_sender_is_tail   = {VC_NUM{1'b0}};
        xfer_s                   = 1'b0;
        case (state_r)
            IDLE: begin
                // Stray body flits are swallowed so the link cannot wedge
                bus.Noc_receive_ready = bus.Noc_receive_valid & ~bus.Noc_receive_is_header;
            end
            ALLOC: begin
                bus.Noc_receive_ready = 1'b0;
            end
            BUSY: begin
                bus.Noc_sender_valid[vc_idx_r]     = bus.Noc_receive_valid;
                bus.Noc_sender_flit[vc_idx_r*DATA_WIDTH +: DATA_WIDTH] = bus.Noc_receive_flit;
                bus.Noc_sender_is_header[vc_idx_r] = bus.Noc_receive_is_header;
                bus.Noc_sender_is_tail[vc_idx_r]   = bus.Noc_receive_is_tail;
                bus.Noc_receive_ready              = bus.Noc_sender_ready[vc_idx_r];
                xfer_s = bus.Noc_receive_valid & bus.Noc_sender_ready[vc_idx_r];
            end
            default: begin
                bus.Noc_receive_ready = 1'b0;
            end
        endcase
    end

    // Next-state logic for the allocation FSM and its binding registers
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        vc_idx_nxt_s   = vc_idx_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        drop_err_nxt_s = drop_err_r;
        case (state_r)
            IDLE: begin
                if (bus.Noc_receive_valid) begin
                    if (bus.Noc_receive_is_header) begin
                        state_nxt_s = ALLOC;
                    end else begin
                        drop_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ALLOC: begin
                if (found_s) begin
                    state_nxt_s  = BUSY;
                    vc_idx_nxt_s = win_s;
                    grant_nxt_s  = {{(VC_NUM-1){1'b0}}, 1'b1} << win_s;
                end else begin
                    state_nxt_s = ALLOC;
                end
            end
            BUSY: begin
                // Only the tail releases the binding; a stray header is just data
                if (xfer_s && bus.Noc_receive_is_tail) begin
                    state_nxt_s  = IDLE;
                    grant_nxt_s  = {VC_NUM{1'b0}};
                    rr_ptr_nxt_s = wrap_inc(vc_idx_r);
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {VC_NUM{1'b0}};
            end
        endcase
    end

    // FSM state, binding and sticky error registers
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_r    <= IDLE;
            grant_r    <= {VC_NUM{1'b0}};
            vc_idx_r   <= {PTR_W{1'b0}};
            rr_ptr_r   <= {PTR_W{1'b0}};
            drop_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            vc_idx_r   <= vc_idx_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            drop_err_r <= drop_err_nxt_s;
        end
    end

    assign bus.Noc_vc_grant = grant_r;
    assign bus.Noc_vc_busy  = (state_r == BUSY);
    assign bus.Noc_drop_err = drop_err_r;

`ifdef NOC_VC_STALL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_PRE   = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt_r;
    logic             timeout_r;

    // Stall watchdog: counts BUSY cycles without a transfer, saturates at the limit
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
        end else if ((state_r == BUSY) && !xfer_s) begin
            if (stall_cnt_r != TO_LIMIT) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            // Pulse coincides with the counter first reaching the limit
            timeout_r <= (stall_cnt_r == TO_PRE);
        end else begin
            stall_cnt_r <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
        end
    end

    assign Noc_timeout = timeout_r;
`endif

endmodule

// File: doc/noc_vc_alloc_demux.md
Name: noc_vc_alloc_demux

Overview:
- Parametrised packet-level virtual-channel allocator and demultiplexer for one NoC input link.
- Binds each incoming packet to one free VC chosen round-robin among VCs reporting VCready.
- Holds the binding from header to tail and steers flits and backpressure to/from the bound VC.
- Sits between a link receiver and the per-VC input buffers of a router port. Generalises the fixed 2-VC tail-switched selector to VC_NUM channels with fair allocation and malformed-packet handling.

Parameters:
- DATA_WIDTH, `Noc_Data_Width, flit width in bits.
- VC_NUM, 2, number of virtual channels (2..8).
- TIMEOUT_CYCLES, 1024, stall watchdog limit (used only with the optional feature).

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  asynchronous active-low reset.
- Noc_receive_valid  in  1  upstream flit valid.
- Noc_receive_ready  out  1  upstream flit accepted when valid&ready.
- Noc_receive_flit  in  DATA_WIDTH  upstream flit.
- Noc_receive_is_header  in  1  flit is packet header.
- Noc_receive_is_tail  in  1  flit is packet tail (header&tail = single-flit packet).
- Noc_sender_valid  out  VC_NUM  per-VC valid.
- Noc_sender_ready  in  VC_NUM  per-VC ready.
- Noc_sender_flit  out  VC_NUM*DATA_WIDTH  per-VC flit; VC i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- Noc_sender_VCready  in  VC_NUM  VC i free to accept a new packet.
- Noc_sender_is_header  out  VC_NUM  per-VC header flag.
- Noc_sender_is_tail  out  VC_NUM  per-VC tail flag.
- Noc_vc_grant  out  VC_NUM  one-hot bound VC; all zero when idle.
- Noc_vc_busy  out  1  a packet is bound.
- Noc_drop_err  out  1  sticky flag: non-header flit discarded while idle.

Behaviour:
- Reset (asynchronous, any state, including mid-packet): state IDLE, grant=0, rr_ptr=0, Noc_drop_err=0.
  - All outputs 0 except Noc_receive_ready, which follows the IDLE rule below.
  - A packet in flight at reset is abandoned; no tail is emitted.
- FSM states: IDLE, ALLOC, BUSY.
- IDLE:
  - valid & !is_header: Noc_receive_ready=1; flit is discarded; Noc_drop_err set next cycle.
  - valid & is_header: Noc_receive_ready=0; go to ALLOC.
  - !valid: Noc_receive_ready=0.
- ALLOC:
  - Noc_receive_ready=0.
  - Search VCready starting at index rr_ptr, wrapping modulo VC_NUM; first set bit wins.
  - Winner k is registered into grant. Next state BUSY.
  - No VC ready: stay in ALLOC and re-evaluate every cycle.
  - Allocation latency: header presented in cycle t is forwardable no earlier than cycle t+2.
- BUSY:
  - Combinational forwarding to VC k only: sender_valid[k]=receive_valid, flit/header/tail copied, Noc_receive_ready=sender_ready[k].
  - All other VCs: valid, flit and flags driven 0.
  - VCready is ignored while BUSY.
  - On a transfer with is_tail=1: next state IDLE, grant=0, rr_ptr=(k+1) mod VC_NUM.
  - A header arriving in BUSY (missing tail) is forwarded as a normal flit; no error is raised.
- Throughput: one flit per cycle in BUSY; minimum 2 idle cycles between back-to-back packets.
- Noc_vc_busy=1 exactly in BUSY. Noc_vc_grant reflects the grant register.
- Noc_drop_err clears only on reset.

Optional Feature:
- Macro NOC_VC_STALL_TIMEOUT_EN.
- Defined:
  - Adds a stall counter that clears on any transfer or when leaving BUSY, and increments each BUSY cycle without a transfer.
  - When the counter reaches TIMEOUT_CYCLES, a 1-cycle pulse is driven on extra output Noc_timeout and the counter saturates.
  - Forwarding is unaffected and the binding is not aborted.
- Not defined: no counter and no Noc_timeout port.
- All other behaviour is identical in both builds.

Test Plan:
- VC_NUM=4, VCready=4'b1111, 3-flit packet (H, 0xA5, T), all ready=1 -> grant=4'b0001 two cycles after H; flits appear only on VC0; IDLE after T; rr_ptr=1.
- Four back-to-back 1-flit packets (header&tail), VCready=4'b1111 -> grants 0001, 0010, 0100, 1000 in order; each packet takes 3 cycles.
- VCready=4'b0000 for 5 cycles then 4'b0100 -> stays in ALLOC with receive_ready=0 for 5 cycles; then grant=4'b0100.
- BUSY on VC1, sender_ready[1] low for 3 cycles mid-packet -> receive_ready=0 for those 3 cycles; flit held stable; no loss or duplication; VC0/2/3 valid stay 0.
- Body flit (is_header=0) in IDLE -> receive_ready=1 that cycle; nothing forwarded; Noc_drop_err=1 from the next cycle until reset.
- Reset asserted mid-packet on VC2 -> all sender_valid=0 and grant=0 immediately; with NOC_VC_STALL_TIMEOUT_EN and TIMEOUT_CYCLES=8, a fresh packet stalled 8 cycles gives one Noc_timeout pulse.
